// File: rtl/cpu_isa_pkg.sv
// ============================================================================
//  Module  : cpu_isa_pkg
//  Purpose : ISA definitions shared by the instruction encoder and the CPU
//            control unit decode: mnemonic codes, opcodes, R-type functs, the
//            loader FSM state type and word-packing helpers.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_isa_pkg;

   // Request mnemonic codes as presented on req_mnem
   typedef enum logic [3:0] {
      MN_ADD  = 4'd0,
      MN_SUB  = 4'd1,
      MN_AND  = 4'd2,
      MN_OR   = 4'd3,
      MN_SLT  = 4'd4,
      MN_NOP  = 4'd5,
      MN_ADDI = 4'd6,
      MN_ANDI = 4'd7,
      MN_ORI  = 4'd8,
      MN_SLTI = 4'd9,
      MN_SW   = 4'd10,
      MN_LW   = 4'd11,
      MN_J    = 4'd12,
      MN_BNE  = 4'd13,
      MN_BEQ  = 4'd14,
      MN_ILL  = 4'd15
   } mnem_e;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] c_op_rtype = 6'b000000;
   localparam logic [5:0] c_op_addi  = 6'b001000;
   localparam logic [5:0] c_op_andi  = 6'b001100;
   localparam logic [5:0] c_op_ori   = 6'b001101;
   localparam logic [5:0] c_op_slti  = 6'b001010;
   localparam logic [5:0] c_op_sw    = 6'b101011;
   localparam logic [5:0] c_op_lw    = 6'b100011;
   localparam logic [5:0] c_op_bne   = 6'b000101;
   localparam logic [5:0] c_op_beq   = 6'b000100;
   localparam logic [5:0] c_op_j     = 6'b000010;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] c_fn_add = 6'b100000;
   localparam logic [5:0] c_fn_sub = 6'b100010;
   localparam logic [5:0] c_fn_and = 6'b100100;
   localparam logic [5:0] c_fn_or  = 6'b100101;
   localparam logic [5:0] c_fn_slt = 6'b101010;

   // Loader FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCEPT = 2'd1,
      ST_WRITE  = 2'd2,
      ST_DONE   = 2'd3
   } load_state_e;

   function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
      return {c_op_rtype, rs, rt, rd, 5'b00000, funct};
   endfunction

   function automatic logic [31:0] pack_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm16);
      return {op, rs, rt, imm16};
   endfunction

   function automatic logic [31:0] pack_j(input logic [25:0] target);
      return {c_op_j, target};
   endfunction

endpackage

`default_nettype wire

// File: rtl/instr_load_encoder_if.sv
// ============================================================================
//  Module  : instr_load_encoder_if
//  Purpose : Request handshake from the boot host plus the imem write port of
//            the instruction loader.
//  Ports   : req_valid/req_ready handshake, req_mnem/rs/rt/rd/imm/last fields,
//            imem_we/imem_addr/imem_wdata write port.
//            master = host side, slave = encoder side.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface instr_load_encoder_if #(
   parameter int AW = 5
);
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_mnem;
   logic [4:0]    req_rs;
   logic [4:0]    req_rt;
   logic [4:0]    req_rd;
   logic [25:0]   req_imm;
   logic          req_last;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   modport master (
      output req_valid, req_mnem, req_rs, req_rt, req_rd, req_imm, req_last,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, req_mnem, req_rs, req_rt, req_rd, req_imm, req_last,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/mips_instr_encode.sv
// ============================================================================
//  Module  : mips_instr_encode
//  Purpose : Purely combinational mnemonic + fields -> 32-bit MIPS word.
//            Fields not used by a format are forced to zero; NOP and the
//            unassigned code 15 both produce 32'h0.
//  Ports   : mnem (4), rs/rt/rd (5), imm (26)  -> word (32)
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mips_instr_encode
   import cpu_isa_pkg::*;
(
   input  logic [3:0]  mnem,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [25:0] imm,
   output logic [31:0] word
);

   always_comb begin
      word = 32'h0;
      case (mnem_e'(mnem))
         MN_ADD  : word = pack_r(rs, rt, rd, c_fn_add);
         MN_SUB  : word = pack_r(rs, rt, rd, c_fn_sub);
         MN_AND  : word = pack_r(rs, rt, rd, c_fn_and);
         MN_OR   : word = pack_r(rs, rt, rd, c_fn_or);
         MN_SLT  : word = pack_r(rs, rt, rd, c_fn_slt);
         MN_ADDI : word = pack_i(c_op_addi, rs, rt, imm[15:0]);
         MN_ANDI : word = pack_i(c_op_andi, rs, rt, imm[15:0]);
         MN_ORI  : word = pack_i(c_op_ori,  rs, rt, imm[15:0]);
         MN_SLTI : word = pack_i(c_op_slti, rs, rt, imm[15:0]);
         MN_SW   : word = pack_i(c_op_sw,   rs, rt, imm[15:0]);
         MN_LW   : word = pack_i(c_op_lw,   rs, rt, imm[15:0]);
         MN_BNE  : word = pack_i(c_op_bne,  rs, rt, imm[15:0]);
         MN_BEQ  : word = pack_i(c_op_beq,  rs, rt, imm[15:0]);
         MN_J    : word = pack_j(imm);
         default : word = 32'h0;   // NOP and code 15
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/instr_load_encoder.sv
// ============================================================================
//  Module  : instr_load_encoder
//  Purpose : Accepts mnemonic/operand requests, encodes them into MIPS words
//            and writes them sequentially into instruction memory from BASE,
//            holding the CPU in reset until the program has been loaded.
//  Params  : AW   imem word-address width (DEPTH = 2**AW)
//            BASE first imem word address written after start
//  Ports   : clk, rst (async, active high), start (pulse)
//            bus      instr_load_encoder_if.slave (requests + imem write port)
//            cpu_hold, done, overflow (sticky), count (AW+1)
//            err      sticky illegal-mnemonic flag, only with ENC_CHECK_EN
//  Config  : ENC_CHECK_EN  when defined, mnemonic 15 is rejected (no write,
//            err set); otherwise it is written as a NOP.
//  Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_load_encoder
   import cpu_isa_pkg::*;
#(
   parameter int AW   = 5,
   parameter int BASE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   instr_load_encoder_if.slave  bus,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 overflow,
`ifdef ENC_CHECK_EN
   output logic                 err,
`endif
   output logic [AW:0]          count
);

   localparam logic [AW-1:0] c_base      = AW'(BASE);
   localparam logic [AW-1:0] c_last_addr = '1;
   localparam logic [AW-1:0] c_addr_one  = AW'(1);
   localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);

   load_state_e   r_state;
   load_state_e   w_next;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_word;
   logic          r_last;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [31:0]   w_word;
   logic          w_ready;
   logic          w_we;
   logic          w_illegal;

   mips_instr_encode u_encode (
      .mnem (bus.req_mnem),
      .rs   (bus.req_rs),
      .rt   (bus.req_rt),
      .rd   (bus.req_rd),
      .imm  (bus.req_imm),
      .word (w_word)
   );

`ifdef ENC_CHECK_EN
   logic r_err;
   assign w_illegal = (bus.req_mnem == MN_ILL);
   assign err       = r_err;
`else
   assign w_illegal = 1'b0;
`endif

   // Next-state and handshake/strobe decode
   always_comb begin
      w_next  = r_state;
      w_ready = 1'b0;
      w_we    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_ACCEPT;
         end
         ST_ACCEPT: begin
            w_ready = 1'b1;
            if (bus.req_valid) begin
               // A rejected word skips WRITE entirely
               if (w_illegal) w_next = bus.req_last ? ST_DONE : ST_ACCEPT;
               else           w_next = ST_WRITE;
            end
         end
         ST_WRITE: begin
            w_we = 1'b1;
            // Filling the top slot without a last flag ends the load (no wrap)
            if (r_last || (r_addr == c_last_addr)) w_next = ST_DONE;
            else                                   w_next = ST_ACCEPT;
         end
         ST_DONE: begin
            if (start) w_next = ST_ACCEPT;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_addr     <= c_base;
         r_word     <= 32'h0;
         r_last     <= 1'b0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_addr     <= c_base;
                  r_count    <= '0;
                  r_overflow <= 1'b0;
               end
            end
            ST_ACCEPT: begin
               if (bus.req_valid && !w_illegal) begin
                  r_word <= w_word;
                  r_last <= bus.req_last;
               end
            end
            ST_WRITE: begin
               r_count <= r_count + c_cnt_one;
               // Address saturates at the top slot rather than wrapping
               if (r_addr != c_last_addr) r_addr <= r_addr + c_addr_one;
               else if (!r_last)          r_overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef ENC_CHECK_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                                 r_err <= 1'b0;
      else if (start && (r_state == ST_IDLE || r_state == ST_DONE)) r_err <= 1'b0;
      else if (r_state == ST_ACCEPT && bus.req_valid && w_illegal)  r_err <= 1'b1;
   end
`endif

   assign bus.req_ready  = w_ready;
   assign bus.imem_we    = w_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_word;
   assign cpu_hold       = (r_state != ST_DONE);
   assign done           = (r_state == ST_DONE);
   assign overflow       = r_overflow;
   assign count          = r_count;

endmodule

`default_nettype wire
